// File: rtl/rst_seq_ctrl.sv
// Board reset sequencer: waits for stable PLL lock, then
// releases reset domains one by one with a fixed gap.
module rst_seq_ctrl #(
  parameter int NUM_STAGES = 4,
  parameter int LOCK_CYC   = 16,
  parameter int STAGE_DLY  = 8,
  parameter int HOLD_CYC   = 16,
  parameter int CNT_W      = 20
) (
  input  logic                  clk,
  input  logic                  resetn_in,
  input  logic                  pll_locked,
  input  logic                  soft_rst_req,
  output logic [NUM_STAGES-1:0] rst_n,
  output logic                  done,
  output logic [2:0]            state
);

  localparam int SW = $clog2(NUM_STAGES + 1);

  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST  = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [SW-1:0]    STG_LAST  = SW'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ONE  = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RELEASE   = 3'd2,
    RUN       = 3'd3,
    SOFT_HOLD = 3'd4
  } state_t;

  logic [1:0]       rstn_sync;
  logic [1:0]       lock_sync;
  logic             rstn_s;
  logic             lock_s;
  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [SW-1:0]    stg;

  assign rstn_s = rstn_sync[1];
  assign lock_s = lock_sync[1];
  assign state  = st;

  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      rstn_sync <= '0;
      lock_sync <= '0;
    end else begin
      rstn_sync <= {rstn_sync[0], 1'b1};
      lock_sync <= {lock_sync[0], pll_locked};
    end
  end

  always_ff @(posedge clk or negedge resetn_in) begin
    if (!resetn_in) begin
      st    <= HOLD;
      cnt   <= '0;
      stg   <= '0;
      rst_n <= '0;
      done  <= 1'b0;
    end else begin
      unique case (st)
        HOLD: begin
          rst_n <= '0;
          done  <= 1'b0;
          if (rstn_s) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end
        end
        WAIT_LOCK: begin
          rst_n <= '0;
          done  <= 1'b0;
          if (!lock_s) begin
            cnt <= '0;
          end else if (cnt == LOCK_LAST) begin
            st  <= RELEASE;
            cnt <= DLY_LAST;
            stg <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RELEASE: begin
          if (!lock_s) begin
            st    <= WAIT_LOCK;
            cnt   <= '0;
            rst_n <= '0;
            done  <= 1'b0;
          end else if (cnt == '0) begin
            rst_n <= rst_n | (ONE << stg);
            stg   <= stg + 1'b1;
            cnt   <= DLY_LAST;
            if (stg == STG_LAST) begin
              st   <= RUN;
              done <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            st    <= WAIT_LOCK;
            cnt   <= '0;
            rst_n <= '0;
            done  <= 1'b0;
          end else if (soft_rst_req) begin
            st    <= SOFT_HOLD;
            cnt   <= HOLD_LAST;
            rst_n <= '0;
            done  <= 1'b0;
          end else begin
            rst_n <= '1;
            done  <= 1'b1;
          end
        end
        SOFT_HOLD: begin
          rst_n <= '0;
          done  <= 1'b0;
          // Lock loss and hold expiry both land in WAIT_LOCK
          if (!lock_s || cnt == '0) begin
            st  <= WAIT_LOCK;
            cnt <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          st    <= HOLD;
          cnt   <= '0;
          rst_n <= '0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Testbench for rst_seq_ctrl: timing-level reference model
// plus directed literal checks and randomized lock/soft/reset traffic.
module tb_rst_seq_ctrl;

  localparam int NS = 4;
  localparam int LC = 16;
  localparam int SD = 8;
  localparam int HC = 16;

  logic          clk = 1'b0;
  logic          resetn_in = 1'b1;
  logic          pll_locked = 1'b1;
  logic          soft_rst_req = 1'b0;
  logic [NS-1:0] rst_n;
  logic          done;
  logic [2:0]    state;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  rst_seq_ctrl #(
    .NUM_STAGES(NS),
    .LOCK_CYC(LC),
    .STAGE_DLY(SD),
    .HOLD_CYC(HC),
    .CNT_W(20)
  ) dut (
    .clk(clk),
    .resetn_in(resetn_in),
    .pll_locked(pll_locked),
    .soft_rst_req(soft_rst_req),
    .rst_n(rst_n),
    .done(done),
    .state(state)
  );

  always #5 clk = ~clk;

  // Model: phase id plus cycles spent in that phase
  int m_st = 0;
  int m_t  = 0;
  int m_rc = 0;
  bit m_lk0 = 1'b0;
  bit m_lk1 = 1'b0;
  bit m_ls;
  bit m_rs;

  initial forever begin
    @(posedge clk or negedge resetn_in);
    if (!resetn_in) begin
      m_st = 0; m_t = 0; m_rc = 0;
      m_lk0 = 1'b0; m_lk1 = 1'b0;
    end else begin
      m_ls = m_lk1;
      m_rs = (m_rc >= 2);
      case (m_st)
        0: if (m_rs) begin m_st = 1; m_t = 0; end
        1: begin
          if (!m_ls) m_t = 0;
          else if (m_t + 1 == LC) begin m_st = 2; m_t = 0; end
          else m_t++;
        end
        2: begin
          if (!m_ls) begin m_st = 1; m_t = 0; end
          else begin
            m_t++;
            if (m_t == SD * NS) m_st = 3;
          end
        end
        3: begin
          if (!m_ls) begin m_st = 1; m_t = 0; end
          else if (soft_rst_req) begin m_st = 4; m_t = 0; end
        end
        4: begin
          if (!m_ls) begin m_st = 1; m_t = 0; end
          else begin
            m_t++;
            if (m_t == HC) begin m_st = 1; m_t = 0; end
          end
        end
        default: m_st = 0;
      endcase
      m_lk1 = m_lk0;
      m_lk0 = pll_locked;
      if (m_rc < 2) m_rc++;
    end
  end

  function automatic logic [NS-1:0] exp_rst();
    int n;
    if (m_st == 3) return '1;
    if (m_st != 2) return '0;
    n = m_t / SD;
    if (n >= NS) return '1;
    return NS'((1 << n) - 1);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("rst_n", 32'(rst_n), 32'(exp_rst()));
      chk("done", 32'(done), 32'(m_st == 3));
      chk("state", 32'(state), 32'(m_st));
    end
  end

  task automatic tick(int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_state(int s, logic [NS-1:0] r, bit use_r,
                            int budget, string nm);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      if (state == 3'(s) && (!use_r || rst_n == r)) found = 1'b1;
      else tick(1);
    end
    chk(nm, 32'(found), 32'd1);
  endtask

  // Expects resetn_in low on entry; cycle n is edge e-3
  task automatic power_up();
    int n;
    pll_locked = 1'b1;
    tick(3);
    resetn_in = 1'b1;
    for (int e = 1; e <= 51; e++) begin
      tick(1);
      n = e - 3;
      case (n)
        15: begin
          chk("pu15_state", 32'(state), 32'd1);
          chk("pu15_rst", 32'(rst_n), 32'h0);
        end
        16: begin
          chk("pu16_state", 32'(state), 32'd2);
          chk("pu16_rst", 32'(rst_n), 32'h0);
        end
        23: chk("pu23_rst", 32'(rst_n), 32'h0);
        24: chk("pu24_rst", 32'(rst_n), 32'h1);
        31: chk("pu31_rst", 32'(rst_n), 32'h1);
        32: chk("pu32_rst", 32'(rst_n), 32'h3);
        40: chk("pu40_rst", 32'(rst_n), 32'h7);
        47: begin
          chk("pu47_rst", 32'(rst_n), 32'h7);
          chk("pu47_done", 32'(done), 32'd0);
        end
        48: begin
          chk("pu48_rst", 32'(rst_n), 32'hf);
          chk("pu48_done", 32'(done), 32'd1);
          chk("pu48_state", 32'(state), 32'd3);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int first;
    int lk_hold;
    int sf_hold;
    int rs_hold;

    tick(2);
    resetn_in = 1'b0;
    cmp_en = 1'b1;
    tick(1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_rst", 32'(rst_n), 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    power_up();
    tick(5);

    // Soft reset held high for 20 cycles: no retrigger
    soft_rst_req = 1'b1;
    first = -1;
    for (int k = 0; k < 200 && first < 0; k++) begin
      tick(1);
      if (k == 0) begin
        chk("soft_state", 32'(state), 32'd4);
        chk("soft_rst", 32'(rst_n), 32'h0);
        chk("soft_done", 32'(done), 32'd0);
      end
      if (k == 19) soft_rst_req = 1'b0;
      if (done) first = k;
    end
    chk("soft_done_lat", 32'(first), 32'd64);
    tick(3);

    // 1-cycle lock glitch seen at WAIT_LOCK count 10
    soft_rst_req = 1'b1;
    first = -1;
    for (int k = 0; k < 200 && first < 0; k++) begin
      tick(1);
      if (k == 0) soft_rst_req = 1'b0;
      if (k == 24) pll_locked = 1'b0;
      if (k == 25) pll_locked = 1'b1;
      if (k == 42) chk("glitch_wait", 32'(state), 32'd1);
      if (k == 43) begin
        chk("glitch_rel", 32'(state), 32'd2);
        chk("glitch_rst", 32'(rst_n), 32'h0);
      end
      if (done) first = k;
    end
    chk("glitch_done_lat", 32'(first), 32'd75);
    tick(3);

    // Lock loss while rst_n == 0011
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    wait_state(2, 4'b0011, 1'b1, 300, "rel_0011_reached");
    pll_locked = 1'b0;
    tick(2);
    chk("ll_b_state", 32'(state), 32'd2);
    chk("ll_b_rst", 32'(rst_n), 32'h3);
    tick(1);
    chk("ll_c_state", 32'(state), 32'd1);
    chk("ll_c_rst", 32'(rst_n), 32'h0);
    tick(4);
    pll_locked = 1'b1;
    wait_state(3, '0, 1'b0, 200, "ll_run_reached");
    tick(2);

    // Lock loss and soft request on the same edge
    pll_locked = 1'b0;
    tick(2);
    soft_rst_req = 1'b1;
    tick(1);
    chk("sim_state", 32'(state), 32'd1);
    chk("sim_rst", 32'(rst_n), 32'h0);
    soft_rst_req = 1'b0;
    tick(2);
    pll_locked = 1'b1;
    wait_state(3, '0, 1'b0, 200, "sim_run_reached");

    // Asynchronous board reset in the middle of RELEASE
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    wait_state(2, 4'b0111, 1'b1, 300, "rel_0111_reached");
    @(posedge clk);
    #3;
    resetn_in = 1'b0;
    #1;
    chk("async_state", 32'(state), 32'd0);
    chk("async_rst", 32'(rst_n), 32'h0);
    chk("async_done", 32'(done), 32'd0);
    tick(2);
    power_up();

    // Randomized lock loss, soft requests and board resets
    lk_hold = 0;
    sf_hold = 0;
    rs_hold = 0;
    repeat (4000) begin
      tick(1);
      if (rs_hold > 0) begin
        rs_hold--;
        if (rs_hold == 0) resetn_in = 1'b1;
      end else if ($urandom_range(0, 999) == 0) begin
        resetn_in = 1'b0;
        rs_hold = $urandom_range(1, 3);
      end
      if (lk_hold > 0) begin
        lk_hold--;
        if (lk_hold == 0) pll_locked = 1'b1;
      end else if ($urandom_range(0, 249) == 0) begin
        pll_locked = 1'b0;
        lk_hold = $urandom_range(1, 12);
      end
      if (sf_hold > 0) begin
        sf_hold--;
        if (sf_hold == 0) soft_rst_req = 1'b0;
      end else if ($urandom_range(0, 59) == 0) begin
        soft_rst_req = 1'b1;
        sf_hold = $urandom_range(1, 24);
      end
    end
    resetn_in = 1'b1;
    pll_locked = 1'b1;
    soft_rst_req = 1'b0;
    tick(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
